// File: rtl/jk_stim_driver_pkg.sv
// Shared types for the jk_ff stimulus driver.
//   jk_op_t  : 2-bit command opcode; the encoding is exactly {j, k}.
//   jk_cmd_t : queued command {op, cnt}; the op is replayed cnt+1 cycles.
//   jk_next  : next-state function of a JK flop (also reused by benches).
package jk_pkg;

    // Width of the cnt field carried in jk_cmd_t.
    // The driver's CNT_W parameter must match it.
    localparam int unsigned JK_CNT_W = 4;

    typedef enum logic [1:0] {
        OpHold = 2'b00,
        OpClr  = 2'b01,
        OpSet  = 2'b10,
        OpTog  = 2'b11
    } jk_op_t;

    typedef struct packed {
        jk_op_t                op;
        logic [JK_CNT_W-1:0]   cnt;
    } jk_cmd_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nq;
        case ({j, k})
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_stim_driver_if.sv
// Command handshake bundle for jk_stim_driver.
//   cmd_valid : command offered
//   cmd_ready : driver can accept (FIFO not full)
//   cmd_op    : opcode, see jk_op_t
//   cmd_cnt   : repeat count, op is driven cmd_cnt+1 cycles
// master = command source, slave = jk_stim_driver.
interface jk_stim_driver_if
    import jk_pkg::*;
#(
    parameter int unsigned CNT_W = JK_CNT_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    jk_op_t           cmd_op;
    logic [CNT_W-1:0] cmd_cnt;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cnt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cnt,
        output cmd_ready
    );

endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO of jk_cmd_t, DEPTH entries (power of two, >= 2).
//   clk, rst : clock and synchronous active-high reset (flushes the FIFO)
//   push     : write wdata at the tail (ignored while full)
//   wdata    : command to write
//   pop      : advance the head (ignored while empty)
//   rdata    : current head entry (valid while !empty)
//   full     : occupancy == DEPTH
//   empty    : occupancy == 0
module jk_cmd_fifo
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  jk_cmd_t wdata,
    input  logic    pop,
    output jk_cmd_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    jk_cmd_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/jk_stim_driver.sv
// Command-driven stimulus stage generating J/K for a downstream jk_ff.
// Commands {op, cnt} are queued in a FIFO and each op is replayed on j/k
// for cnt+1 cycles; consecutive commands follow each other with no gap.
//   clk, rst : clock and synchronous active-high reset
//   bus      : command handshake (slave side)
//   j, k     : registered J/K to the flop
//   busy     : a command is running or queued
//   q        : Q fed back from the flop (checker only)
//   exp_q    : modelled Q (checker only)
//   err      : sticky Q mismatch flag (checker only)
// Build option: define JK_STIM_CHECK_EN to include the Q checker; otherwise
// exp_q and err are tied to 0 and q is ignored.
module jk_stim_driver
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = JK_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    jk_stim_driver_if.slave    bus,
    output logic               j,
    output logic               k,
    output logic               busy,
    input  logic               q,
    output logic               exp_q,
    output logic               err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [JK_CNT_W-1:0] rem_q, rem_d;
    logic                j_q, j_d;
    logic                k_q, k_d;

    jk_cmd_t push_cmd;
    jk_cmd_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    pop;

    assign push_cmd.op  = bus.cmd_op;
    assign push_cmd.cnt = JK_CNT_W'(bus.cmd_cnt);

    // Ready comes from registered occupancy only: no path from cmd_valid.
    assign bus.cmd_ready = !fifo_full;

    jk_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        j_d     = j_q;
        k_d     = k_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    rem_d        = head.cnt;
                    {j_d, k_d}   = head.op;
                    state_d      = StRun;
                end else begin
                    j_d = 1'b0;
                    k_d = 1'b0;
                end
            end
            StRun: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end else if (!fifo_empty) begin
                    // Load the next command on the last cycle: no bubble.
                    pop        = 1'b1;
                    rem_d      = head.cnt;
                    {j_d, k_d} = head.op;
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign j    = j_q;
    assign k    = k_q;
    assign busy = (state_q == StRun) || !fifo_empty;

`ifdef JK_STIM_CHECK_EN
    logic exp_q_q;
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            exp_q_q <= jk_next(exp_q_q, j_q, k_q);
            if (q != exp_q_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign exp_q = exp_q_q;
    assign err   = err_q;
`else
    logic unused_q;
    assign unused_q = q;
    assign exp_q    = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: doc/jk_stim_driver.md
# jk_stim_driver

Command-driven stimulus stage sitting directly upstream of the `jk_ff` block; it generates that flop's `j`/`k` inputs. Callers push (operation, repeat-count) commands over a valid/ready handshake into a small FIFO, and the block replays each command on `j`/`k` for the requested number of cycles. An optional checker models the flop and compares its `Q` against the expected value.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `CNT_W`, 4: width of the repeat-count field.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset; shared with the downstream `jk_ff`.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_op`  in  2  00 HOLD (j=0,k=0), 01 CLR (j=0,k=1), 10 SET (j=1,k=0), 11 TOG (j=1,k=1).
- `cmd_cnt`  in  CNT_W  repeat count; the op is driven for `cmd_cnt+1` cycles.
- `j`  out  1  to `jk_ff` J, registered.
- `k`  out  1  to `jk_ff` K, registered.
- `busy`  out  1  FSM in RUN or FIFO non-empty.
- `q`  in  1  `Q` fed back from `jk_ff`; used only by the checker.
- `exp_q`  out  1  modelled `Q`; checker only.
- `err`  out  1  sticky mismatch flag; checker only.

## Operation
- Push: on a rising edge with `cmd_valid && cmd_ready`, `{cmd_op, cmd_cnt}` is written to the FIFO tail. If `cmd_valid` is high while the FIFO is full, nothing is written and the caller must hold the command.
- FSM states: IDLE and RUN.
  - IDLE: if the FIFO is non-empty, pop the head, load `op` and `rem = cnt`, register `j`/`k` from `op`, and go to RUN. If the FIFO is empty, `j=k=0`.
  - RUN: on each edge with `rem != 0`, decrement `rem` and keep `j`/`k`. On the edge with `rem == 0`:
    - if the FIFO is non-empty, pop the next command and load it with no bubble cycle;
    - otherwise drive `j=k=0` and go to IDLE.
- Concurrent push and pop in the same cycle are both performed; the occupancy count is unchanged. `cmd_ready` depends only on registered occupancy, so there is no combinational path from `cmd_valid`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. The count register is `$clog2(DEPTH)+1` bits.
- `rst` clears everything: FIFO flushed, state IDLE, `j=0`, `k=0`, `rem=0`, `exp_q=0`, `err=0`. Reset in the middle of a command discards the command. The first valid push is accepted on the edge after `rst` is released.

## Timing
- Reset values: `cmd_ready=1`, `j=0`, `k=0`, `busy=0`, `exp_q=0`, `err=0`.
- Latency: a command accepted at edge E0 appears on `j`/`k` after edge E1 and holds for `cnt+1` cycles, until edge E1+cnt+1.
- Back-to-back commands are contiguous on `j`/`k`.
- `busy` falls in the same cycle that `j`/`k` return to 0 after the last command.
- Checker: on each edge, `exp_q` is updated from the current `j`/`k` using JK semantics (hold/0/1/invert). `err` is set on any edge where `q != exp_q` and stays set until `rst`.

## Configuration
- Macro `JK_STIM_CHECK_EN`.
- Defined: the `exp_q` model and the `err` logic are present.
- Undefined:
  - `exp_q` and `err` are tied to 0;
  - `q` is unused;
  - no checker flops are instantiated;
  - FIFO and FSM behaviour are unchanged.

## Structure
- Shared package `jk_pkg`:
  - `jk_op_t` enum (HOLD, CLR, SET, TOG) with 2-bit encoding;
  - `jk_cmd_t` struct `{op, cnt}`;
  - function `jk_next(q, j, k)` returning the next `Q`, reused by benches.
- Sub-module `jk_cmd_fifo`: synchronous FIFO of `jk_cmd_t`, parameterised by `DEPTH`, providing `full`/`empty`/push/pop.
- Top level: FSM, output registers and the optional checker.

## Test plan
- Reset then idle: `rst` high for 2 cycles, no commands → `j=k=0`, `busy=0`, `cmd_ready=1`, `err=0`.
- Single SET, cnt=2: accepted at E0 → `j=1,k=0` for exactly 3 cycles starting after E1, then 0/0; `exp_q` becomes 1 one edge after `j` rises.
- Back-to-back sequence SET(0), CLR(0), TOG(3), HOLD(1) → `j`/`k` = 10, 01, 11×4, 00×2 with no gaps; with the flop attached, `Q` = 1, 0, 1, 0, 1, 0, 0, 0 and `err` stays 0.
- Push six TOG(15) commands with DEPTH=4 → `cmd_ready` drops after the 5th accept (4 in FIFO plus 1 in RUN), rises the cycle after the next pop, and no command is lost or duplicated.
- Reset mid-TOG(15) after 5 cycles → next cycle `j=k=0`, FIFO empty, `busy=0`, `err=0`; a subsequent CLR(0) executes normally.
- With `JK_STIM_CHECK_EN` defined, force `q` to 1 while `exp_q=0` for one cycle → `err=1` on that edge and it remains 1 until `rst`.
